// File: rtl/pca_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pca_pkg
// Description : Shared PCA datapath defaults and the covariance-reader state type.
// Revision    : 1.0 - initial release
// ============================================================================
package pca_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_N      = 4;
  localparam int WORD_W     = DEF_N * DEF_DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/cov_bram_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : cov_bram_reader_if
// Description : BRAM port B and matrix valid/ready bundle of the covariance reader.
// Revision    : 1.0 - initial release
// ============================================================================
interface cov_bram_reader_if #(
  parameter int DATA_W = pca_pkg::DEF_DATA_W,
  parameter int N      = pca_pkg::DEF_N,
  parameter int ADDR_W = 2
);

  logic                    start;
  logic                    enb;
  logic [ADDR_W-1:0]       addrb;
  logic [N*DATA_W-1:0]     doutb;
  logic [N*N*DATA_W-1:0]   mat_out;
  logic                    mat_valid;
  logic                    mat_ready;
  logic                    busy;
  logic                    sym_err;

  modport master (
    input  start, doutb, mat_ready,
    output enb, addrb, mat_out, mat_valid, busy, sym_err
  );

  modport slave (
    output start, doutb, mat_ready,
    input  enb, addrb, mat_out, mat_valid, busy, sym_err
  );

endinterface
`default_nettype wire

// File: rtl/cov_rd_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : cov_rd_tag_pipe
// Description : RD_LAT-deep {valid,row} shift register aligning captures with BRAM data.
// Revision    : 1.0 - initial release
// ============================================================================
module cov_rd_tag_pipe #(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 2
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              tag_vld_i,
  input  wire logic [ADDR_W-1:0] tag_row_i,
  output logic                   cap_en_o,
  output logic [ADDR_W-1:0]      cap_row_o,
  output logic                   inflight_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] row_q [RD_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LAT; i++) row_q[i] <= '0;
    end else begin
      vld_q[0] <= tag_vld_i;
      row_q[0] <= tag_row_i;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        row_q[i] <= row_q[i-1];
      end
    end
  end

  assign cap_en_o   = vld_q[RD_LAT-1];
  assign cap_row_o  = row_q[RD_LAT-1];
  assign inflight_o = |vld_q;

endmodule
`default_nettype wire

// File: rtl/cov_bram_reader.sv
`default_nettype none
// ============================================================================
// Module      : cov_bram_reader
// Description : Reads the N x N covariance matrix from BRAM port B and hands it
//               downstream over valid/ready. Optional macro: COV_SYMCHK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cov_bram_reader
  import pca_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int N      = DEF_N,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input wire logic        clk,
  input wire logic        rst,
  cov_bram_reader_if.master bus
);

  localparam int                ROW_W    = N * DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N - 1);

  rd_state_e           state_q;
  logic                enb_q;
  logic [ADDR_W-1:0]   addrb_q;
  logic [N*ROW_W-1:0]  mat_q;
  logic                mat_valid_q;
  logic                busy_q;
  logic                sym_err_q;

  logic                cap_en;
  logic [ADDR_W-1:0]   cap_row;
  logic                inflight;
  logic                sym_mis_d;

  // The tag follows the address the BRAM samples on the same edge as enb_q/addrb_q.
  cov_rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .tag_vld_i  (enb_q),
    .tag_row_i  (addrb_q),
    .cap_en_o   (cap_en),
    .cap_row_o  (cap_row),
    .inflight_o (inflight)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mat_q <= '0;
    end else if (cap_en) begin
      for (int r = 0; r < N; r++) begin
        if (cap_row == ADDR_W'(r)) mat_q[r*ROW_W +: ROW_W] <= bus.doutb;
      end
    end
  end

`ifdef COV_SYMCHK_EN
  always_comb begin
    sym_mis_d = 1'b0;
    for (int r = 0; r < N; r++) begin
      for (int c = r + 1; c < N; c++) begin
        if (mat_q[(r*N+c)*DATA_W +: DATA_W] != mat_q[(c*N+r)*DATA_W +: DATA_W])
          sym_mis_d = 1'b1;
      end
    end
  end
`else
  assign sym_mis_d = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      enb_q       <= 1'b0;
      addrb_q     <= '0;
      mat_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sym_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ISSUE;
            enb_q   <= 1'b1;
            addrb_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ISSUE: begin
          if (addrb_q == LAST_ROW) begin
            state_q <= DRAIN;
            enb_q   <= 1'b0;
            addrb_q <= '0;
          end else begin
            addrb_q <= addrb_q + ADDR_W'(1);
          end
        end
        // Empty tag pipe means the final row landed on the previous edge.
        DRAIN: begin
          if (!inflight) begin
            state_q     <= HOLD;
            mat_valid_q <= 1'b1;
            sym_err_q   <= sym_mis_d;
          end
        end
        HOLD: begin
          if (bus.mat_ready) begin
            state_q     <= IDLE;
            mat_valid_q <= 1'b0;
            sym_err_q   <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.enb       = enb_q;
  assign bus.addrb     = addrb_q;
  assign bus.mat_out   = mat_q;
  assign bus.mat_valid = mat_valid_q;
  assign bus.busy      = busy_q;
  assign bus.sym_err   = sym_err_q;

endmodule
`default_nettype wire

// File: tb/tb_cov_bram_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cov_bram_reader
// Description : Self-checking bench; RD_LAT=1 and RD_LAT=2 readers share one BRAM image.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cov_bram_reader;

  localparam int DW    = 8;
  localparam int NN    = 4;
  localparam int AW    = 2;
  localparam int ROW_W = NN * DW;
  localparam int MAT_W = NN * NN * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mat_ready = 1'b0;
  logic sel = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ROW_W-1:0] mem [NN];

  always #5 clk = ~clk;

  cov_bram_reader_if #(.DATA_W(DW), .N(NN), .ADDR_W(AW)) b1 ();
  cov_bram_reader_if #(.DATA_W(DW), .N(NN), .ADDR_W(AW)) b2 ();

  cov_bram_reader #(.DATA_W(DW), .N(NN), .ADDR_W(AW), .RD_LAT(1)) u_lat1 (
    .clk (clk), .rst (rst), .bus (b1.master)
  );
  cov_bram_reader #(.DATA_W(DW), .N(NN), .ADDR_W(AW), .RD_LAT(2)) u_lat2 (
    .clk (clk), .rst (rst), .bus (b2.master)
  );

  // BRAM models: one and two cycles of read latency.
  logic [ROW_W-1:0] b1_q, b2_s1, b2_s2;
  always @(posedge clk) if (b1.enb) b1_q <= mem[b1.addrb];
  always @(posedge clk) begin
    if (b2.enb) b2_s1 <= mem[b2.addrb];
    b2_s2 <= b2_s1;
  end
  assign b1.doutb     = b1_q;
  assign b2.doutb     = b2_s2;
  assign b1.start     = start & ~sel;
  assign b2.start     = start & sel;
  assign b1.mat_ready = mat_ready;
  assign b2.mat_ready = mat_ready;

  logic             o_enb, o_valid, o_busy, o_sym;
  logic [AW-1:0]    o_addrb;
  logic [MAT_W-1:0] o_mat;
  assign o_enb   = sel ? b2.enb       : b1.enb;
  assign o_valid = sel ? b2.mat_valid : b1.mat_valid;
  assign o_busy  = sel ? b2.busy      : b1.busy;
  assign o_sym   = sel ? b2.sym_err   : b1.sym_err;
  assign o_addrb = sel ? b2.addrb     : b1.addrb;
  assign o_mat   = sel ? b2.mat_out   : b1.mat_out;

  // Reference model
  function automatic logic [MAT_W-1:0] ref_matrix();
    logic [MAT_W-1:0] m;
    m = '0;
    for (int r = 0; r < NN; r++) m[r*ROW_W +: ROW_W] = mem[r];
    return m;
  endfunction

  function automatic bit exp_sym();
    bit a;
    a = 1'b0;
`ifdef COV_SYMCHK_EN
    for (int r = 0; r < NN; r++)
      for (int c = r + 1; c < NN; c++)
        if (mem[r][c*DW +: DW] != mem[c][r*DW +: DW]) a = 1'b1;
`endif
    return a;
  endfunction

  // Observations of one run
  int               r_vedge, r_enb_n, r_vcycles;
  bit               r_seq_ok, r_stable_ok, r_busy_ok, r_idle_ok;
  logic             r_snap_sym, r_sym_after, r_busy_after, r_valid_after;
  logic [MAT_W-1:0] r_snap;

  task automatic do_run(input int hold, input bit mid_start);
    r_vedge = -1; r_enb_n = 0; r_vcycles = 0;
    r_seq_ok = 1; r_stable_ok = 1; r_busy_ok = 1; r_idle_ok = 1;
    r_snap = '0; r_snap_sym = 1'b0;
    mat_ready = (hold == 0);
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (r_vedge >= 0 && !o_valid) break;
      if (o_busy !== 1'b1) r_busy_ok = 0;
      if (o_enb) begin
        if (o_addrb !== AW'(r_enb_n) || k != r_enb_n || r_vedge >= 0) r_seq_ok = 0;
        r_enb_n++;
      end
      if (o_valid) begin
        if (r_vedge < 0) begin
          r_vedge = k; r_snap = o_mat; r_snap_sym = o_sym;
        end else if (o_mat !== r_snap || o_sym !== r_snap_sym) begin
          r_stable_ok = 0;
        end
        r_vcycles++;
        if (r_vcycles >= hold) mat_ready = 1'b1;
      end
      start = mid_start && (r_vcycles == 5);
    end
    start = 1'b0;
    r_busy_after = o_busy; r_sym_after = o_sym; r_valid_after = o_valid;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_enb || o_busy || o_valid) r_idle_ok = 0;
    end
    mat_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mat_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if ({b1.enb, b1.addrb, b1.mat_valid, b1.busy, b1.sym_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl_lat1: got %b want 000000", {b1.enb, b1.addrb, b1.mat_valid, b1.busy, b1.sym_err}); end
    n_tests++; if ({b2.enb, b2.addrb, b2.mat_valid, b2.busy, b2.sym_err} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl_lat2: got %b want 000000", {b2.enb, b2.addrb, b2.mat_valid, b2.busy, b2.sym_err}); end
    n_tests++; if (b1.mat_out !== '0 || b2.mat_out !== '0) begin
      n_fail++; $display("FAIL reset_mat: got %h / %h want 0", b1.mat_out, b2.mat_out); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_ramp();
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) mem[r][c*DW +: DW] = DW'(4*r + c);
  endtask

  task automatic test_basic();
    sel = 1'b0; load_ramp();
    do_run(0, 1'b0);
    n_tests++; if (r_vedge !== 6) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", r_vedge); end
    n_tests++; if (r_enb_n !== NN || !r_seq_ok) begin n_fail++; $display("FAIL basic_addr_seq: enb cycles %0d seq_ok %0d want 4/1", r_enb_n, r_seq_ok); end
    n_tests++; if (r_vcycles !== 1) begin n_fail++; $display("FAIL basic_valid_len: got %0d want 1", r_vcycles); end
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) begin
        n_tests++; if (r_snap[(r*NN+c)*DW +: DW] !== DW'(4*r + c)) begin
          n_fail++; $display("FAIL basic_elem[%0d][%0d]: got %h want %h", r, c, r_snap[(r*NN+c)*DW +: DW], 4*r + c); end
      end
    n_tests++; if (r_busy_after !== 1'b0 || !r_busy_ok || !r_idle_ok) begin
      n_fail++; $display("FAIL basic_busy: after %b run_ok %0d idle_ok %0d want 0/1/1", r_busy_after, r_busy_ok, r_idle_ok); end
  endtask

  task automatic test_hold_backpressure();
    sel = 1'b0; load_ramp();
    do_run(10, 1'b1);
    n_tests++; if (r_vcycles !== 10 || r_valid_after !== 1'b0) begin
      n_fail++; $display("FAIL hold_valid_len: got %0d (after %b) want 10 (0)", r_vcycles, r_valid_after); end
    n_tests++; if (!r_stable_ok || r_snap !== ref_matrix()) begin
      n_fail++; $display("FAIL hold_mat_stable: got %h stable %0d want %h", r_snap, r_stable_ok, ref_matrix()); end
    n_tests++; if (r_enb_n !== NN || !r_seq_ok) begin
      n_fail++; $display("FAIL hold_no_restart: enb cycles %0d seq_ok %0d want 4/1", r_enb_n, r_seq_ok); end
    n_tests++; if (r_busy_after !== 1'b0 || !r_idle_ok) begin
      n_fail++; $display("FAIL hold_idle_after: busy %b idle_ok %0d want 0/1", r_busy_after, r_idle_ok); end
  endtask

  task automatic test_rdlat2();
    sel = 1'b1; load_ramp();
    do_run(0, 1'b0);
    n_tests++; if (r_vedge !== 7) begin n_fail++; $display("FAIL lat2_latency: got %0d want 7", r_vedge); end
    n_tests++; if (r_snap !== ref_matrix()) begin n_fail++; $display("FAIL lat2_matrix: got %h want %h", r_snap, ref_matrix()); end
    n_tests++; if (r_enb_n !== NN || !r_seq_ok || !r_idle_ok) begin
      n_fail++; $display("FAIL lat2_addr_seq: enb cycles %0d seq_ok %0d idle_ok %0d want 4/1/1", r_enb_n, r_seq_ok, r_idle_ok); end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_issue();
    sel = 1'b0;
    for (int r = 0; r < NN; r++) mem[r] = ROW_W'($urandom);
    mat_ready = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    n_tests++; if (o_enb !== 1'b1 || o_addrb !== 2'd1) begin
      n_fail++; $display("FAIL rstmid_reach_addr1: enb %b addrb %0d want 1/1", o_enb, o_addrb); end
    rst = 1'b1;
    #1;
    n_tests++; if ({o_enb, o_addrb, o_valid, o_busy, o_sym} !== 6'b0 || o_mat !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: ctrl %b mat %h want 0", {o_enb, o_addrb, o_valid, o_busy, o_sym}, o_mat); end
    @(negedge clk); rst = 1'b0;
    do_run(0, 1'b0);
    n_tests++; if (r_vedge !== 6 || r_enb_n !== NN || !r_seq_ok) begin
      n_fail++; $display("FAIL rstmid_rerun_timing: vedge %0d enb %0d seq %0d want 6/4/1", r_vedge, r_enb_n, r_seq_ok); end
    n_tests++; if (r_snap !== ref_matrix()) begin n_fail++; $display("FAIL rstmid_rerun_matrix: got %h want %h", r_snap, ref_matrix()); end
  endtask

  task automatic test_random();
    logic [DW-1:0] v;
    int hold, lat;
    for (int it = 0; it < 8; it++) begin
      sel = 1'($urandom_range(0, 1));
      lat = sel ? 2 : 1;
      if ($urandom_range(0, 1) == 1) begin
        for (int r = 0; r < NN; r++)
          for (int c = r; c < NN; c++) begin
            v = DW'($urandom);
            mem[r][c*DW +: DW] = v;
            mem[c][r*DW +: DW] = v;
          end
      end else begin
        for (int r = 0; r < NN; r++) mem[r] = ROW_W'($urandom);
      end
      hold = $urandom_range(0, 4);
      do_run(hold, 1'b0);
      n_tests++; if (r_vedge !== NN + lat + 1) begin
        n_fail++; $display("FAIL rand%0d_latency: got %0d want %0d", it, r_vedge, NN + lat + 1); end
      n_tests++; if (r_snap !== ref_matrix() || !r_stable_ok) begin
        n_fail++; $display("FAIL rand%0d_matrix: got %h want %h", it, r_snap, ref_matrix()); end
      n_tests++; if (r_vcycles !== ((hold > 1) ? hold : 1)) begin
        n_fail++; $display("FAIL rand%0d_valid_len: got %0d want %0d", it, r_vcycles, (hold > 1) ? hold : 1); end
      n_tests++; if (r_snap_sym !== exp_sym() || r_sym_after !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_sym: got %b after %b want %b after 0", it, r_snap_sym, r_sym_after, exp_sym()); end
    end
    sel = 1'b0;
  endtask

  task automatic test_symchk();
    sel = 1'b0;
    for (int r = 0; r < NN; r++)
      for (int c = 0; c < NN; c++) mem[r][c*DW +: DW] = DW'(r + c);
    do_run(0, 1'b0);
    n_tests++; if (r_snap_sym !== 1'b0) begin n_fail++; $display("FAIL sym_clean: got %b want 0", r_snap_sym); end
    mem[1][DW-1:0] = 8'h55;
    do_run(3, 1'b0);
    n_tests++; if (r_snap_sym !== exp_sym() || !r_stable_ok) begin
      n_fail++; $display("FAIL sym_broken: got %b stable %0d want %b", r_snap_sym, r_stable_ok, exp_sym()); end
    n_tests++; if (r_sym_after !== 1'b0) begin n_fail++; $display("FAIL sym_cleared: got %b want 0", r_sym_after); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_backpressure();
    test_rdlat2();
    test_reset_mid_issue();
    test_random();
    test_symchk();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
